// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, types and helpers for the clk_div_bank slice.
//   MIN_DIV    : smallest legal period, in clk cycles
//   DFLT_DIV_W : default period-field width
//   ch_cfg_t   : one channel request {div, en} at the default width
//   div_legal  : period legality check used by the config decoder
package clk_div_pkg;

   localparam int MIN_DIV    = 2;
   localparam int DFLT_DIV_W = 8;

   typedef struct packed {
      logic [DFLT_DIV_W-1:0] div;
      logic                  en;
   } ch_cfg_t;

   function automatic logic div_legal(input int unsigned d);
      return d >= MIN_DIV;
   endfunction

endpackage

// File: rtl/clk_div_bank_ch.sv
// clk_div_ch: one divided-clock channel.
//   clk, rst          : bench clock, synchronous active-high reset
//   load, div, en     : accepted config for this channel (one-cycle strobe)
//   pend              : a config is parked in the shadow, waiting for a boundary
//   ch_clk, ch_tick   : registered divided clock and its rising-edge pulse
//   ch_active         : channel running
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int RST_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   input  logic             en,
   output logic             pend,
   output logic             ch_clk,
   output logic             ch_tick,
   output logic             ch_active
);

   typedef struct packed {
      logic [DIV_W-1:0] div;
      logic             en;
   } shadow_t;

   logic [DIV_W-1:0] cnt, cnt_n, per, per_n;
   shadow_t          shd, shd_n;
   logic             pend_n, act_n, bnd;

   assign bnd = (cnt == per - 1'b1);

   always_comb begin
      cnt_n  = cnt;
      per_n  = per;
      act_n  = ch_active;
      pend_n = pend;
      shd_n  = shd;
      if (ch_active) begin
         // Changes only land on a boundary so no runt pulse is emitted.
         if (bnd) begin
            cnt_n = '0;
            if (pend) begin
               per_n  = shd.div;
               act_n  = shd.en;
               pend_n = 1'b0;
            end
         end else begin
            cnt_n = cnt + 1'b1;
         end
         // pend is registered, so a request taken in a boundary cycle
         // waits for the next boundary. load never arrives while pend=1.
         if (load) begin
            shd_n  = '{div: div, en: en};
            pend_n = 1'b1;
         end
      end else if (load) begin
         per_n = div;
         act_n = en;
         cnt_n = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         per       <= DIV_W'(RST_DIV);
         shd       <= '0;
         pend      <= 1'b0;
         ch_active <= 1'b0;
         ch_clk    <= 1'b0;
         ch_tick   <= 1'b0;
      end else begin
         cnt       <= cnt_n;
         per       <= per_n;
         shd       <= shd_n;
         pend      <= pend_n;
         ch_active <= act_n;
         // Outputs come from next-state so they line up with the counter.
         ch_clk    <= act_n & (cnt_n < (per_n >> 1));
         ch_tick   <= act_n & (cnt_n == '0);
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH programmable clock dividers behind one valid/ready port.
//   clk, rst                    : bench clock, synchronous active-high reset
//   cfg_valid/cfg_ready         : config handshake; ready = channel not pending
//   cfg_ch, cfg_div, cfg_en     : target channel, period, enable
//   cfg_err                     : one-cycle pulse after a rejected transfer
//   ch_clk, ch_tick, ch_active  : per-channel outputs
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter  int NUM_CH  = 4,
   parameter  int DIV_W   = 8,
   parameter  int RST_DIV = 4,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              cfg_en,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] ch_clk,
   output logic [NUM_CH-1:0] ch_tick,
   output logic [NUM_CH-1:0] ch_active
);

   localparam int PAD = 1 << CH_W;

   logic [NUM_CH-1:0] pend_v, load_v;
   logic [PAD-1:0]    pend_pad;
   logic              in_rng, xfer, bad;

   // Unused channel codes read as not-pending, so they are always ready.
   always_comb begin
      pend_pad             = '0;
      pend_pad[NUM_CH-1:0] = pend_v;
   end

   generate
      if (PAD > NUM_CH) begin : g_rng
         assign in_rng = (cfg_ch < CH_W'(NUM_CH));
      end else begin : g_full
         assign in_rng = 1'b1;
      end
   endgenerate

   assign cfg_ready = ~pend_pad[cfg_ch];
   assign xfer      = cfg_valid & cfg_ready;
   assign bad       = ~in_rng | ~div_legal(32'(cfg_div));

   always_ff @(posedge clk) begin
      if (rst) cfg_err <= 1'b0;
      else     cfg_err <= xfer & bad;
   end

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         assign load_v[i] = xfer & ~bad & (cfg_ch == CH_W'(i));
         clk_div_ch #(.DIV_W(DIV_W), .RST_DIV(RST_DIV)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .load      (load_v[i]),
            .div       (cfg_div),
            .en        (cfg_en),
            .pend      (pend_v[i]),
            .ch_clk    (ch_clk[i]),
            .ch_tick   (ch_tick[i]),
            .ch_active (ch_active[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank. Three channels leave channel code 3 unused, so the
// out-of-range rejection path is reachable with a 2-bit cfg_ch.
module tb_clk_div_bank;

   localparam int NUM_CH  = 3;
   localparam int DIV_W   = 8;
   localparam int RST_DIV = 4;
   localparam int CH_W    = 2;

   logic              clk = 1'b0;
   logic              rst, cfg_valid, cfg_ready, cfg_en, cfg_err;
   logic [CH_W-1:0]   cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic [NUM_CH-1:0] ch_clk, ch_tick, ch_active;

   clk_div_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_DIV(RST_DIV)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en), .cfg_err(cfg_err),
      .ch_clk(ch_clk), .ch_tick(ch_tick), .ch_active(ch_active)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Timeline model: a running channel is described by the edge where its
   // current period started and its length; outputs follow from the phase.
   int  cyc = 0;
   bit  chk_on = 0;
   bit  m_act[NUM_CH], m_pend[NUM_CH], m_sen[NUM_CH], m_err;
   int  m_per[NUM_CH], m_start[NUM_CH], m_apply[NUM_CH], m_sdiv[NUM_CH];

   always @(posedge clk) begin : model
      bit in_rng, rdy, hs, bad;
      int c;
      cyc++;
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_act[i] = 0; m_pend[i] = 0; m_per[i] = RST_DIV; m_start[i] = cyc;
         end
         m_err  = 0;
         chk_on = 1;
      end else begin
         c      = int'(cfg_ch);
         in_rng = c < NUM_CH;
         rdy    = !in_rng || !m_pend[c];
         hs     = cfg_valid && rdy;
         bad    = !in_rng || cfg_div < 2;
         for (int i = 0; i < NUM_CH; i++)
            if (m_pend[i] && m_apply[i] == cyc) begin
               m_per[i] = m_sdiv[i]; m_act[i] = m_sen[i]; m_start[i] = cyc; m_pend[i] = 0;
            end
         m_err = hs && bad;
         if (hs && !bad) begin
            if (m_act[c]) begin
               // first period start strictly after this edge
               m_apply[c] = m_start[c] + m_per[c] * ((cyc - m_start[c]) / m_per[c] + 1);
               m_sdiv[c]  = int'(cfg_div); m_sen[c] = cfg_en; m_pend[c] = 1;
            end else begin
               m_per[c] = int'(cfg_div); m_act[c] = cfg_en; m_start[c] = cyc;
            end
         end
      end
   end

   always @(negedge clk) begin : cmp
      logic [NUM_CH-1:0] e_clk, e_tick, e_act;
      logic e_rdy;
      int ph;
      if (chk_on) begin
         for (int i = 0; i < NUM_CH; i++) begin
            ph = m_act[i] ? (cyc - m_start[i]) % m_per[i] : 0;
            e_act[i]  = m_act[i];
            e_clk[i]  = m_act[i] && (ph < m_per[i] / 2);
            e_tick[i] = m_act[i] && (ph == 0);
         end
         e_rdy = (int'(cfg_ch) < NUM_CH) ? !m_pend[cfg_ch] : 1'b1;
         chk("m_ch_clk",    32'(ch_clk),    32'(e_clk));
         chk("m_ch_tick",   32'(ch_tick),   32'(e_tick));
         chk("m_ch_active", 32'(ch_active), 32'(e_act));
         chk("m_cfg_ready", 32'(cfg_ready), 32'(e_rdy));
         chk("m_cfg_err",   32'(cfg_err),   32'(m_err));
      end
   end

   // Driver: inputs change 2 time units after a posedge.
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic cfg(input int ch, input int dv, input bit en);
      cfg_ch = CH_W'(ch); cfg_div = DIV_W'(dv); cfg_en = en; cfg_valid = 1;
      #1;
      for (int i = 0; i < 64 && !cfg_ready; i++) begin @(posedge clk); #3; end
      chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
      @(posedge clk); #2;
      cfg_valid = 0;
   endtask

   task automatic wait_tick(input int ch);
      bit seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin @(posedge clk); #1; seen = ch_tick[ch]; end
      chk("tick_wait", 32'(seen), 32'd1);
      #1;
   endtask

   task automatic grab(input int ch, input int n,
                       output logic [15:0] clks, output logic [15:0] ticks, output logic [15:0] acts);
      clks = '0; ticks = '0; acts = '0;
      for (int i = 0; i < n; i++) begin
         clks  = {clks[14:0],  ch_clk[ch]};
         ticks = {ticks[14:0], ch_tick[ch]};
         acts  = {acts[14:0],  ch_active[ch]};
         if (i < n - 1) begin @(posedge clk); #2; end
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [15:0] c, t, a;
      rst = 1; cfg_valid = 0; cfg_ch = '0; cfg_div = '0; cfg_en = 0;
      repeat (2) @(posedge clk);
      #2 rst = 0;
      chk("rst_active", 32'(ch_active), 32'd0);
      chk("rst_clk",    32'(ch_clk),    32'd0);
      chk("rst_ready",  32'(cfg_ready), 32'd1);
      chk("rst_err",    32'(cfg_err),   32'd0);

      // ch0 P=4: tick right after handshake, clock 1100
      cfg(0, 4, 1);
      grab(0, 8, c, t, a);
      chk("p4_clk",  32'(c), 32'h00CC);
      chk("p4_tick", 32'(t), 32'h0088);

      // ch1 P=6, switch to P=3 at cnt=2: old period finishes (cnt 3,4,5)
      cfg(1, 6, 1);
      wait_tick(1);
      idle(2);
      cfg(1, 3, 1);
      chk("pend_ready_ch1", 32'(cfg_ready), 32'd0);
      cfg_ch = 2'd2; #1;
      chk("pend_ready_ch2", 32'(cfg_ready), 32'd1);
      grab(1, 9, c, t, a);
      chk("p6to3_clk",  32'(c), 32'h0024);
      chk("p6to3_tick", 32'(t), 32'h0024);

      // rejections: illegal period, then unused channel code
      cfg(2, 1, 1);
      chk("err_div",     32'(cfg_err),      32'd1);
      chk("err_div_act", 32'(ch_active[2]), 32'd0);
      idle(1);
      chk("err_div_end", 32'(cfg_err), 32'd0);
      cfg(3, 5, 1);
      chk("err_ch", 32'(cfg_err), 32'd1);
      idle(1);
      chk("err_ch_end", 32'(cfg_err), 32'd0);

      // disable ch0 at cnt=1: cnt 2,3 still run, then inactive
      wait_tick(0);
      idle(1);
      cfg(0, 4, 0);
      grab(0, 6, c, t, a);
      chk("dis_clk",  32'(c), 32'h0000);
      chk("dis_tick", 32'(t), 32'h0000);
      chk("dis_act",  32'(a), 32'h0030);

      // ch2 P=5 reconfigured exactly at cnt=4: one more P=5, then P=2
      cfg(2, 5, 1);
      wait_tick(2);
      idle(4);
      cfg(2, 2, 1);
      grab(2, 7, c, t, a);
      chk("bnd_clk",  32'(c), 32'h0062);
      chk("bnd_tick", 32'(t), 32'h0042);

      // reset with ch1 pending
      cfg(1, 7, 1);
      rst = 1;
      @(posedge clk); #2;
      rst = 0;
      chk("mid_rst_clk",  32'(ch_clk),    32'd0);
      chk("mid_rst_tick", 32'(ch_tick),   32'd0);
      chk("mid_rst_act",  32'(ch_active), 32'd0);
      cfg_ch = 2'd1; #1;
      chk("mid_rst_ready", 32'(cfg_ready), 32'd1);
      #1;
      cfg(0, RST_DIV, 1);
      grab(0, 8, c, t, a);
      chk("rst_p4_clk", 32'(c), 32'h00CC);

      // back-to-back handshakes on different channels
      cfg(1, 2, 1);
      cfg(2, 3, 1);
      idle(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
